// File: rtl/mixed_c_hdr_deframer_pkg.sv
// -----------------------------------------------------------------------------
// mixed_c_hdr_deframer_pkg
// Shared types and constants for the mixedBlockC header deframer.
// A 13-bit cHeaderSt travels as three 5-bit seeSt beats, LSB beat first.
// The top two bits of the last beat are pad.
// -----------------------------------------------------------------------------
package mixed_c_hdr_deframer_pkg;

    localparam int HDR_W       = 13;  // cHeaderSt width (cBiggerT)
    localparam int BEAT_W      = 5;   // seeSt width (cSizeT + cSizePlusT)
    localparam int CNT_W       = 16;  // delivered-header counter width
    localparam int C_HDR_BEATS = 3;   // beats per header
    localparam int C_HDR_PAD_W = 2;   // pad bits in the last beat

    // Beats 0 and 1 are held in the accumulator until the last beat arrives.
    localparam int ACC_W  = (C_HDR_BEATS - 1) * BEAT_W;
    // Payload bits carried by the last beat.
    localparam int LAST_W = BEAT_W - C_HDR_PAD_W;

    typedef logic [BEAT_W-1:0] see_st_t;      // {variablec[1:0], variablec2[2:0]}
    typedef logic [HDR_W-1:0]  c_header_st_t;

    typedef enum logic [1:0] {
        B0 = 2'd0,
        B1 = 2'd1,
        B2 = 2'd2
    } hdr_beat_t;

    // True when any pad bit of a last beat is set.
    function automatic logic pad_nonzero(input see_st_t beat);
        return |beat[BEAT_W-1 -: C_HDR_PAD_W];
    endfunction

endpackage

// File: rtl/mixed_c_hdr_outreg.sv
// -----------------------------------------------------------------------------
// mixed_c_hdr_outreg
// One-entry registered output stage with valid/ready.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   load           load load_data this cycle (upstream only asserts it when
//                  in_ready is 1)
//   load_data      header to register
//   out_ready      consumer ready
//   out_valid      registered header valid
//   out_data       registered header
//   in_ready       stage can accept a load this cycle (empty or draining)
//   hs             output handshake pulse (out_valid & out_ready)
// -----------------------------------------------------------------------------
module mixed_c_hdr_outreg
    import mixed_c_hdr_deframer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [HDR_W-1:0] load_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [HDR_W-1:0] out_data,
    output logic             in_ready,
    output logic             hs
);

    logic             valid_q, valid_d;
    logic [HDR_W-1:0] data_q,  data_d;

    assign hs        = valid_q & out_ready;
    assign in_ready  = ~valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        valid_d = valid_q;
        data_d  = data_q;
        // A load in the handshake cycle keeps valid high with the new data.
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (hs) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/mixed_c_hdr_deframer.sv
// -----------------------------------------------------------------------------
// mixed_c_hdr_deframer
// Reassembles three 5-bit seeSt beats into one 13-bit cHeaderSt.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   see_valid/see_ready/see_data   input beat stream (beat 0 = header LSBs)
//   hdr_valid/hdr_ready/hdr_data   registered header output
//   abort          drop the partially assembled header
//   pad_err        sticky: a last beat arrived with nonzero pad bits
//   err_clr        clears pad_err (a simultaneous new error wins)
//   hdr_cnt        wrapping count of delivered headers
// -----------------------------------------------------------------------------
module mixed_c_hdr_deframer
    import mixed_c_hdr_deframer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              see_valid,
    output logic              see_ready,
    input  logic [BEAT_W-1:0] see_data,
    output logic              hdr_valid,
    input  logic              hdr_ready,
    output logic [HDR_W-1:0]  hdr_data,
    input  logic              abort,
    output logic              pad_err,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  hdr_cnt
);

    hdr_beat_t        state_q,   state_d;
    logic [ACC_W-1:0] acc_q,     acc_d;
    logic             pad_err_q, pad_err_d;
    logic [CNT_W-1:0] hdr_cnt_q, hdr_cnt_d;

    logic             load;
    logic [HDR_W-1:0] load_data;
    logic             out_in_ready;
    logic             hs;

    mixed_c_hdr_outreg u_outreg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_data),
        .out_ready (hdr_ready),
        .out_valid (hdr_valid),
        .out_data  (hdr_data),
        .in_ready  (out_in_ready),
        .hs        (hs)
    );

    assign pad_err = pad_err_q;
    assign hdr_cnt = hdr_cnt_q;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        pad_err_d = pad_err_q;
        hdr_cnt_d = hdr_cnt_q;
        see_ready = 1'b0;
        load      = 1'b0;
        // Pad bits of the last beat are dropped here.
        load_data = {see_data[LAST_W-1:0], acc_q};

        if (abort) begin
            state_d = B0;
            acc_d   = '0;
        end else begin
            unique case (state_q)
                B0: begin
                    see_ready = 1'b1;
                    if (see_valid) begin
                        acc_d[BEAT_W-1:0] = see_data;
                        state_d           = B1;
                    end
                end
                B1: begin
                    see_ready = 1'b1;
                    if (see_valid) begin
                        acc_d[ACC_W-1:BEAT_W] = see_data;
                        state_d               = B2;
                    end
                end
                B2: begin
                    // Last beat waits until the output register can take it.
                    see_ready = out_in_ready;
                    if (see_valid && out_in_ready) begin
                        load    = 1'b1;
                        state_d = B0;
                    end
                end
                default: state_d = B0;
            endcase
        end

        // Set has priority over clear.
        if (load && pad_nonzero(see_data)) begin
            pad_err_d = 1'b1;
        end else if (err_clr) begin
            pad_err_d = 1'b0;
        end

        if (hs) begin
            hdr_cnt_d = hdr_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= B0;
            // NOTE: the accumulator is a plain register, so it is reset like
            // the rest; abort also zeroes it so stale beats never leak out.
            acc_q     <= '0;
            pad_err_q <= 1'b0;
            hdr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            pad_err_q <= pad_err_d;
            hdr_cnt_q <= hdr_cnt_d;
        end
    end

endmodule

// File: tb/tb_mixed_c_hdr_deframer.sv
// -----------------------------------------------------------------------------
// tb_mixed_c_hdr_deframer
// Directed bench for mixed_c_hdr_deframer. Inputs change on the falling edge,
// outputs are sampled 1 time unit after an edge.
// -----------------------------------------------------------------------------
module tb_mixed_c_hdr_deframer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        see_valid = 1'b0;
    logic        see_ready;
    logic [4:0]  see_data = '0;
    logic        hdr_valid;
    logic        hdr_ready = 1'b1;
    logic [12:0] hdr_data;
    logic        abort = 1'b0;
    logic        pad_err;
    logic        err_clr = 1'b0;
    logic [15:0] hdr_cnt;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    mixed_c_hdr_deframer dut (
        .clk       (clk),
        .rst       (rst),
        .see_valid (see_valid),
        .see_ready (see_ready),
        .see_data  (see_data),
        .hdr_valid (hdr_valid),
        .hdr_ready (hdr_ready),
        .hdr_data  (hdr_data),
        .abort     (abort),
        .pad_err   (pad_err),
        .err_clr   (err_clr),
        .hdr_cnt   (hdr_cnt)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; see_valid = 1'b0; see_data = '0;
        abort = 1'b0; err_clr = 1'b0; hdr_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // Presents one beat and waits (bounded) until it is accepted.
    // Returns 1 time unit after the accepting edge.
    task automatic send_beat(input logic [4:0] d);
        int n;
        n = 0;
        @(negedge clk);
        see_valid = 1'b1;
        see_data  = d;
        #1;
        while (!see_ready && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        n_cmp++;
        if (see_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL send_beat_timeout: see_ready=%b after %0d cycles, required 1", see_ready, n);
        end
        @(posedge clk);
        #1;
        see_valid = 1'b0;
        see_data  = '0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (hdr_valid !== 1'b0) begin n_mis++; $display("FAIL reset_valid: got %b want 0", hdr_valid); end
        n_cmp++; if (hdr_data !== 13'h0) begin n_mis++; $display("FAIL reset_data: got %h want 0000", hdr_data); end
        n_cmp++; if (pad_err !== 1'b0) begin n_mis++; $display("FAIL reset_pad_err: got %b want 0", pad_err); end
        n_cmp++; if (hdr_cnt !== 16'h0) begin n_mis++; $display("FAIL reset_cnt: got %h want 0000", hdr_cnt); end
        n_cmp++; if (see_ready !== 1'b1) begin n_mis++; $display("FAIL reset_see_ready: got %b want 1", see_ready); end
    endtask

    task automatic test_basic();
        send_beat(5'h15);
        send_beat(5'h0A);
        send_beat(5'h07);
        n_cmp++; if (hdr_valid !== 1'b1) begin n_mis++; $display("FAIL basic_valid: got %b want 1", hdr_valid); end
        n_cmp++; if (hdr_data !== 13'h1D55) begin n_mis++; $display("FAIL basic_data: got %h want 1d55", hdr_data); end
        n_cmp++; if (pad_err !== 1'b0) begin n_mis++; $display("FAIL basic_pad_err: got %b want 0", pad_err); end
        @(posedge clk); #1;
        n_cmp++; if (hdr_cnt !== 16'd1) begin n_mis++; $display("FAIL basic_cnt: got %0d want 1", hdr_cnt); end
        n_cmp++; if (hdr_valid !== 1'b0) begin n_mis++; $display("FAIL basic_valid_clear: got %b want 0", hdr_valid); end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  beats [9];
        logic [12:0] exp_hdr [3];
        logic [8:0]  vpat;
        int k;
        int stalls;
        beats   = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h1E, 5'h00, 5'h02};
        exp_hdr = '{13'h0C41, 13'h18A4, 13'h081E};
        vpat = '0; k = 0; stalls = 0;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            see_valid = 1'b1;
            see_data  = beats[i];
            #1;
            if (!see_ready) stalls++;
            if (hdr_valid) begin
                vpat[i] = 1'b1;
                if (k < 3) begin
                    n_cmp++;
                    if (hdr_data !== exp_hdr[k]) begin n_mis++; $display("FAIL b2b_data%0d: got %h want %h", k, hdr_data, exp_hdr[k]); end
                end
                k++;
            end
        end
        @(negedge clk);
        see_valid = 1'b0;
        #1;
        n_cmp++; if (vpat !== 9'h048) begin n_mis++; $display("FAIL b2b_valid_pattern: got %b want 001001000", vpat); end
        n_cmp++; if (stalls !== 0) begin n_mis++; $display("FAIL b2b_see_ready: %0d stall cycles, want 0", stalls); end
        n_cmp++; if (hdr_valid !== 1'b1) begin n_mis++; $display("FAIL b2b_last_valid: got %b want 1", hdr_valid); end
        if (k < 3) begin
            n_cmp++;
            if (hdr_data !== exp_hdr[k]) begin n_mis++; $display("FAIL b2b_data%0d: got %h want %h", k, hdr_data, exp_hdr[k]); end
        end
        @(negedge clk); #1;
        n_cmp++; if (hdr_cnt !== 16'd3) begin n_mis++; $display("FAIL b2b_cnt: got %0d want 3", hdr_cnt); end
        n_cmp++; if (hdr_valid !== 1'b0) begin n_mis++; $display("FAIL b2b_valid_clear: got %b want 0", hdr_valid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        send_beat(5'h15);
        send_beat(5'h0A);
        send_beat(5'h07);
        hdr_ready = 1'b0;
        n_cmp++; if (hdr_data !== 13'h1D55) begin n_mis++; $display("FAIL bp_first_data: got %h want 1d55", hdr_data); end
        // Beats 0 and 1 must still be taken while the output is stalled.
        send_beat(5'h01);
        send_beat(5'h02);
        @(negedge clk);
        see_valid = 1'b1;
        see_data  = 5'h03;
        #1;
        n_cmp++; if (see_ready !== 1'b0) begin n_mis++; $display("FAIL bp_b2_stall: got %b want 0", see_ready); end
        repeat (2) begin
            @(negedge clk); #1;
            n_cmp++; if (hdr_data !== 13'h1D55 || hdr_valid !== 1'b1) begin n_mis++; $display("FAIL bp_hold: got v=%b d=%h want v=1 d=1d55", hdr_valid, hdr_data); end
        end
        @(negedge clk);
        hdr_ready = 1'b1;
        #1;
        n_cmp++; if (see_ready !== 1'b1) begin n_mis++; $display("FAIL bp_release_ready: got %b want 1", see_ready); end
        @(posedge clk); #1;
        see_valid = 1'b0;
        n_cmp++; if (hdr_valid !== 1'b1 || hdr_data !== 13'h0C41) begin n_mis++; $display("FAIL bp_reload: got v=%b d=%h want v=1 d=0c41", hdr_valid, hdr_data); end
        n_cmp++; if (hdr_cnt !== 16'd1) begin n_mis++; $display("FAIL bp_cnt1: got %0d want 1", hdr_cnt); end
        @(posedge clk); #1;
        n_cmp++; if (hdr_valid !== 1'b0 || hdr_cnt !== 16'd2) begin n_mis++; $display("FAIL bp_drain: got v=%b cnt=%0d want v=0 cnt=2", hdr_valid, hdr_cnt); end
    endtask

    task automatic test_pad_err();
        do_reset();
        send_beat(5'h00);
        send_beat(5'h00);
        send_beat(5'h1F);
        n_cmp++; if (hdr_data !== 13'h1C00 || hdr_valid !== 1'b1) begin n_mis++; $display("FAIL pad_data: got v=%b d=%h want v=1 d=1c00", hdr_valid, hdr_data); end
        n_cmp++; if (pad_err !== 1'b1) begin n_mis++; $display("FAIL pad_set: got %b want 1", pad_err); end
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        n_cmp++; if (pad_err !== 1'b0) begin n_mis++; $display("FAIL pad_clr: got %b want 0", pad_err); end
        send_beat(5'h00);
        send_beat(5'h00);
        @(negedge clk);
        see_valid = 1'b1;
        see_data  = 5'h18;
        err_clr   = 1'b1;
        #1;
        n_cmp++; if (see_ready !== 1'b1) begin n_mis++; $display("FAIL pad_b2_ready: got %b want 1", see_ready); end
        @(posedge clk); #1;
        see_valid = 1'b0;
        err_clr   = 1'b0;
        n_cmp++; if (pad_err !== 1'b1) begin n_mis++; $display("FAIL pad_set_wins: got %b want 1", pad_err); end
        n_cmp++; if (hdr_data !== 13'h0000 || hdr_valid !== 1'b1) begin n_mis++; $display("FAIL pad_drop: got v=%b d=%h want v=1 d=0000", hdr_valid, hdr_data); end
    endtask

    task automatic test_abort();
        do_reset();
        send_beat(5'h05);
        send_beat(5'h06);
        @(negedge clk);
        see_valid = 1'b1;
        see_data  = 5'h1F;
        abort     = 1'b1;
        #1;
        n_cmp++; if (see_ready !== 1'b0) begin n_mis++; $display("FAIL abort_ready: got %b want 0", see_ready); end
        @(posedge clk); #1;
        see_valid = 1'b0;
        abort     = 1'b0;
        n_cmp++; if (hdr_valid !== 1'b0 || pad_err !== 1'b0) begin n_mis++; $display("FAIL abort_no_deliver: got v=%b pad=%b want 0 0", hdr_valid, pad_err); end
        send_beat(5'h01);
        send_beat(5'h00);
        send_beat(5'h00);
        n_cmp++; if (hdr_valid !== 1'b1 || hdr_data !== 13'h0001) begin n_mis++; $display("FAIL abort_next_hdr: got v=%b d=%h want v=1 d=0001", hdr_valid, hdr_data); end
        n_cmp++; if (pad_err !== 1'b0) begin n_mis++; $display("FAIL abort_pad: got %b want 0", pad_err); end
    endtask

    task automatic test_cnt_wrap();
        do_reset();
        @(negedge clk);
        force dut.hdr_cnt_q = 16'hFFFF;
        #1;
        release dut.hdr_cnt_q;
        #1;
        n_cmp++; if (hdr_cnt !== 16'hFFFF) begin n_mis++; $display("FAIL wrap_preload: got %h want ffff", hdr_cnt); end
        send_beat(5'h01);
        send_beat(5'h00);
        send_beat(5'h00);
        @(posedge clk); #1;
        n_cmp++; if (hdr_cnt !== 16'h0000) begin n_mis++; $display("FAIL wrap_cnt: got %h want 0000", hdr_cnt); end
    endtask

    task automatic test_rst_mid_header();
        do_reset();
        hdr_ready = 1'b0;
        send_beat(5'h15);
        send_beat(5'h0A);
        send_beat(5'h1F);
        send_beat(5'h01);
        send_beat(5'h02);
        n_cmp++; if (hdr_valid !== 1'b1 || pad_err !== 1'b1) begin n_mis++; $display("FAIL rst_pre: got v=%b pad=%b want 1 1", hdr_valid, pad_err); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (hdr_valid !== 1'b0 || hdr_data !== 13'h0 || pad_err !== 1'b0 || hdr_cnt !== 16'h0) begin
            n_mis++; $display("FAIL rst_outputs: got v=%b d=%h pad=%b cnt=%h want 0 0000 0 0000", hdr_valid, hdr_data, pad_err, hdr_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        hdr_ready = 1'b1;
        send_beat(5'h03);
        send_beat(5'h04);
        send_beat(5'h05);
        n_cmp++; if (hdr_valid !== 1'b1 || hdr_data !== 13'h1483) begin n_mis++; $display("FAIL rst_next_hdr: got v=%b d=%h want v=1 d=1483", hdr_valid, hdr_data); end
        @(posedge clk); #1;
        n_cmp++; if (hdr_cnt !== 16'd1) begin n_mis++; $display("FAIL rst_next_cnt: got %0d want 1", hdr_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_pad_err();
        test_abort();
        test_cnt_wrap();
        test_rst_mid_header();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/mixed_c_hdr_deframer.md
Name: mixed_c_hdr_deframer

Overview:
- Receive side of the mixedBlockC header link. The transmitter sends each 13-bit cHeaderSt as three consecutive 5-bit seeSt beats; this block reassembles those beats into one cHeaderSt.
- Sits between the seeSt link and the header consumer.
- Ready/valid on both sides. Output is registered. Also provides pad-bit error detection, an abort, and a delivered-header counter.

Parameters:
- HDR_W, 13: cHeaderSt width (cBiggerT).
- BEAT_W, 5: seeSt width (cSizeT + cSizePlusT).
- NUM_BEATS, 3: beats per header, fixed as ceil(HDR_W/BEAT_W).
- CNT_W, 16: width of hdr_cnt.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- see_valid  in  1  input beat valid.
- see_ready  out  1  input beat ready.
- see_data  in  5  seeSt beat {variablec[1:0], variablec2[2:0]}.
- hdr_valid  out  1  reassembled header valid.
- hdr_ready  in  1  consumer ready.
- hdr_data  out  13  cHeaderSt.
- abort  in  1  discard the partially assembled header.
- pad_err  out  1  sticky flag: a nonzero pad bit was received.
- err_clr  in  1  clears pad_err.
- hdr_cnt  out  16  count of headers delivered.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: beat state B0, accumulator 0, hdr_valid 0, hdr_data 0, pad_err 0, hdr_cnt 0. see_ready is 1 in the first cycle after reset.
- Beat k (k = 0..2) carries packed seeSt bits [4:0], which map to header bits [5k+4:5k]. Beat 0 holds the LSBs.
- The last beat's bits [4:3] are pad, i.e. header bits 14:13.
- Beat-state FSM:
  - States B0 -> B1 -> B2 -> B0.
  - Advances only on an accepted beat (see_valid & see_ready).
  - B0 and B1 write their beats into accumulator bits [4:0] and [9:5] respectively.
- see_ready:
  - 0 whenever abort = 1.
  - Otherwise 1 in B0 and B1.
  - In B2: !hdr_valid | hdr_ready, so the last beat is accepted only when the output register can be loaded.
- Last-beat acceptance:
  - Next cycle: hdr_data = {beat2[2:0], acc[9:0]} and hdr_valid = 1.
  - FSM returns to B0.
  - If beat2[4:3] != 0, pad_err is set that same cycle. The header is still delivered, with pad bits dropped.
- Latency: hdr_valid asserts 1 cycle after the third beat is accepted.
- Throughput: with hdr_ready held at 1, one header every 3 cycles with no bubbles.
- Output handshake:
  - hdr_valid & hdr_ready clears hdr_valid, unless a new last beat is accepted in the same cycle; then hdr_valid stays 1 and hdr_data takes the new value.
  - hdr_data is stable while hdr_valid & !hdr_ready.
- hdr_cnt increments by 1 on every output handshake and wraps from 0xFFFF to 0.
- abort:
  - FSM returns to B0 and the accumulator is zeroed next cycle.
  - Any beat presented in that cycle is not accepted.
  - The output register, hdr_cnt and pad_err are unaffected.
- Backpressure: in B0 and B1, input beats are still accepted while the output is stalled. Only the B2 beat stalls.
- Simultaneous err_clr and a new pad error: set wins.
- rst mid-header: the partial header is discarded and hdr_valid is dropped with no handshake. hdr_cnt is not incremented.

Decomposition:
- mixedBlockC_package:
  - Already holds seeSt, cHeaderSt, cSizeT, cSizePlusT, cBiggerT.
  - Add constants C_HDR_BEATS = 3 and C_HDR_PAD_W = 2.
  - Add an enum hdrBeatT {B0, B1, B2} for the FSM.
- One natural sub-module: mixed_c_hdr_outreg, the 1-entry output register with valid/ready and the handshake-count pulse. The assembly FSM stays in the top.

Test Plan:
- Beats 0x15, 0x0A, 0x07 with hdr_ready = 1:
  - hdr_data = 0x1D55, 1 cycle after the third beat.
  - pad_err = 0; hdr_cnt = 1.
- Back-to-back headers with see_valid held at 1 and hdr_ready = 1 for 9 beats:
  - 3 headers delivered, hdr_valid pulses every 3 cycles.
  - see_ready never 0; hdr_cnt = 3.
- hdr_ready = 0 after the first header:
  - Second header's beats 0 and 1 are accepted; see_ready = 0 in B2; hdr_data holds the first value.
  - Raise hdr_ready: the last beat is accepted in the handshake cycle and hdr_valid stays 1 with the new data.
- Last beat 0x1F:
  - Header delivered with bits [12:10] = 3'b111; pad_err = 1.
  - err_clr asserted alone -> pad_err = 0.
  - err_clr coincident with another pad error -> pad_err stays 1.
- Two beats accepted, then abort = 1 with see_valid = 1:
  - That beat is not accepted; FSM returns to B0.
  - The next 3 beats 0x01, 0x00, 0x00 produce hdr_data = 0x0001.
- Preload hdr_cnt to 0xFFFF via 65535 headers (or force in sim), then one more handshake -> hdr_cnt = 0.
- rst after 2 beats -> all outputs at reset values; next header assembles correctly.
